// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS-32 pipeline registers: stage states, default widths, NOP control.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned WB_W_DEF       = 2;
  localparam int unsigned MEM_W_DEF      = 3;
  localparam int unsigned EXE_W_DEF      = 4;
  localparam int unsigned CTRL_W_DEF     = WB_W_DEF + MEM_W_DEF + EXE_W_DEF;

  localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer over a packed payload; in_ready_o is registered.
module pipe_skid_buf
  import mips_pipe_pkg::*;
#(
  parameter int unsigned P_W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [P_W-1:0] in_data_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [P_W-1:0] out_data_o
);

  pipe_state_e    state_q, state_d;
  logic [P_W-1:0] main_q, main_d;
  logic [P_W-1:0] skid_q, skid_d;
  logic           in_ready_q, in_ready_d;
  logic           acc, drn;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign in_ready_o  = in_ready_q;

  assign acc = in_valid_i & in_ready_q;
  assign drn = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_FULL;
          main_d  = in_data_i;
        end
      end
      ST_FULL: begin
        if (acc && drn) begin
          main_d = in_data_i;
        end else if (acc) begin
          state_d = ST_SKID;
          skid_d  = in_data_i;
        end else if (drn) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (drn) begin
          state_d = ST_FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops everything; payload registers keep their contents so data outputs hold.
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush and bubble-gated control outputs.
// Optional performance counters are built when ID_EXE_PERF_CNT_EN is defined.
module id_exe_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned WB_W       = WB_W_DEF,
  parameter int unsigned MEM_W      = MEM_W_DEF,
  parameter int unsigned EXE_W      = EXE_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     pc,
  input  logic                  zero,
  input  logic [DATA_W-1:0]     readData1,
  input  logic [DATA_W-1:0]     readData2,
  input  logic [DATA_W-1:0]     sign_extended,
  input  logic [REG_ADDR_W-1:0] instruction1,
  input  logic [REG_ADDR_W-1:0] instruction2,
  input  logic [WB_W-1:0]       WB,
  input  logic [MEM_W-1:0]      MEM,
  input  logic [EXE_W-1:0]      EXE,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     pcOut,
  output logic                  zeroOut,
  output logic [DATA_W-1:0]     readData1Out,
  output logic [DATA_W-1:0]     readData2Out,
  output logic [DATA_W-1:0]     sign_extendedOut,
  output logic [REG_ADDR_W-1:0] instruction1Out,
  output logic [REG_ADDR_W-1:0] instruction2Out,
  output logic [WB_W-1:0]       WBOut,
  output logic [MEM_W-1:0]      MEMOut,
  output logic [EXE_W-1:0]      EXEOut
`ifdef ID_EXE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           bubble_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam int unsigned CtrlW = WB_W + MEM_W + EXE_W;
  localparam int unsigned DataPW = 4 * DATA_W + 1 + 2 * REG_ADDR_W;
  localparam int unsigned PW = DataPW + CtrlW;
  localparam logic [CtrlW-1:0] NopCtrl = CtrlW'(NOP_CTRL);

  logic [PW-1:0]    in_pack, out_pack;
  logic [CtrlW-1:0] ctrl_raw, ctrl_gated;

  assign in_pack = {pc, zero, readData1, readData2, sign_extended, instruction1, instruction2,
                    WB, MEM, EXE};

  pipe_skid_buf #(
    .P_W (PW)
  ) u_skid (
    .clk_i       (clock),
    .rst_i       (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_pack),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_pack)
  );

  assign {pcOut, zeroOut, readData1Out, readData2Out, sign_extendedOut, instruction1Out,
          instruction2Out} = out_pack[PW-1:CtrlW];

  assign ctrl_raw   = out_pack[CtrlW-1:0];
  // An empty stage must look like a NOP to EXE so stale control never writes back.
  assign ctrl_gated = out_valid ? ctrl_raw : NopCtrl;
  assign {WBOut, MEMOut, EXEOut} = ctrl_gated;

`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (in_valid && !in_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (out_ready && !out_valid) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Self-checking bench for id_exe_pipe_reg: queue-based occupancy model plus directed literal pins.
module tb_id_exe_pipe_reg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 9;
  localparam int DPW = 4 * DW + 1 + 2 * RW;
  localparam int PW = DPW + CW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] pc = '0;
  logic          zero = 1'b0;
  logic [DW-1:0] readData1 = '0, readData2 = '0, sign_extended = '0;
  logic [RW-1:0] instruction1 = '0, instruction2 = '0;
  logic [1:0]    WB = '0;
  logic [2:0]    MEM = '0;
  logic [3:0]    EXE = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] pcOut, readData1Out, readData2Out, sign_extendedOut;
  logic          zeroOut;
  logic [RW-1:0] instruction1Out, instruction2Out;
  logic [1:0]    WBOut;
  logic [2:0]    MEMOut;
  logic [3:0]    EXEOut;
`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0]   stall_cnt, bubble_cnt, flush_cnt;
`endif

  id_exe_pipe_reg dut (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .pc               (pc),
    .zero             (zero),
    .readData1        (readData1),
    .readData2        (readData2),
    .sign_extended    (sign_extended),
    .instruction1     (instruction1),
    .instruction2     (instruction2),
    .WB               (WB),
    .MEM              (MEM),
    .EXE              (EXE),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .pcOut            (pcOut),
    .zeroOut          (zeroOut),
    .readData1Out     (readData1Out),
    .readData2Out     (readData2Out),
    .sign_extendedOut (sign_extendedOut),
    .instruction1Out  (instruction1Out),
    .instruction2Out  (instruction2Out),
    .WBOut            (WBOut),
    .MEMOut           (MEMOut),
    .EXEOut           (EXEOut)
`ifdef ID_EXE_PERF_CNT_EN
    ,
    .stall_cnt        (stall_cnt),
    .bubble_cnt       (bubble_cnt),
    .flush_cnt        (flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the stage is a FIFO of at most two accepted instructions; the head is what EXE sees.
  logic [PW-1:0] mq[$];
  logic [PW-1:0] m_last = '0;
  logic          m_in_ready = 1'b1;
  logic          m_live = 1'b0;
  int unsigned   m_stall = 0, m_bubble = 0, m_flush = 0;

  always @(posedge clock) begin
    logic [PW-1:0] cur;
    logic m_acc, m_drn;
    cur = {pc, zero, readData1, readData2, sign_extended, instruction1, instruction2, WB, MEM, EXE};
    if (reset) begin
      mq.delete();
      m_last = '0;
      m_in_ready = 1'b1;
      m_stall = 0;
      m_bubble = 0;
      m_flush = 0;
      m_live = 1'b1;
    end else begin
      if (in_valid && !m_in_ready) m_stall++;
      if (out_ready && mq.size() == 0) m_bubble++;
      if (flush) m_flush++;
      if (flush) begin
        mq.delete();
      end else begin
        m_drn = (mq.size() > 0) && out_ready;
        m_acc = in_valid && m_in_ready;
        if (m_drn) void'(mq.pop_front());
        if (m_acc) mq.push_back(cur);
      end
      m_in_ready = (mq.size() < 2);
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      logic [PW-1:0] head;
      head = m_last;
      chk("out_valid", out_valid, mq.size() > 0);
      chk("in_ready", in_ready, m_in_ready);
      chk("data", {pcOut, zeroOut, readData1Out, readData2Out, sign_extendedOut,
                   instruction1Out, instruction2Out}, head[PW-1:CW]);
      chk("ctrl", {WBOut, MEMOut, EXEOut}, (mq.size() > 0) ? head[CW-1:0] : '0);
`ifdef ID_EXE_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("bubble_cnt", bubble_cnt, m_bubble);
      chk("flush_cnt", flush_cnt, m_flush);
`endif
    end
  end

  task automatic set_in(input logic v, input logic [DW-1:0] p, input logic [CW-1:0] ctrl);
    in_valid = v;
    pc = p;
    zero = p[2];
    readData1 = ~p;
    readData2 = {p[15:0], p[31:16]};
    sign_extended = p ^ 32'h5A5A_5A5A;
    instruction1 = p[6:2];
    instruction2 = p[11:7];
    {WB, MEM, EXE} = ctrl;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [23:0] pat_v, pat_r;
    pat_v = 24'b1011_1110_0111_0101_1101_1011;
    pat_r = 24'b0110_0011_1001_1100_0110_1101;

    reset = 1'b1;
    set_in(1'b1, 32'hDEAD_BEEF, 9'h1FF);
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    set_in(1'b0, 32'h0, 9'h0);
    out_ready = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_pcOut", pcOut, 32'h0);
    chk("rst_rd1Out", readData1Out, 32'h0);
    chk("rst_ctrl", {WBOut, MEMOut, EXEOut}, 9'h0);

    // Streaming
    out_ready = 1'b1;
    set_in(1'b1, 32'h100, 9'h0A5);
    step();
    chk("stream_pc0", pcOut, 32'h100);
    set_in(1'b1, 32'h104, 9'h15A);
    step();
    chk("stream_pc1", pcOut, 32'h104);
    chk("stream_rdy", in_ready, 1'b1);
    set_in(1'b1, 32'h108, 9'h033);
    step();
    chk("stream_pc2", pcOut, 32'h108);
    chk("stream_vld", out_valid, 1'b1);
    set_in(1'b0, 32'h0, 9'h0);
    step();

    // Stall
    out_ready = 1'b0;
    set_in(1'b1, 32'h200, 9'h111);
    step();
    set_in(1'b1, 32'h204, 9'h122);
    step();
    chk("stall_rdy", in_ready, 1'b0);
    chk("stall_pc", pcOut, 32'h200);
    set_in(1'b1, 32'h208, 9'h133);
    step();
    chk("stall_hold", pcOut, 32'h200);
    set_in(1'b0, 32'h0, 9'h0);
    out_ready = 1'b1;
    step();
    chk("unstall_pc", pcOut, 32'h204);
    chk("unstall_rdy", in_ready, 1'b1);

    // Flush while both entries are held
    out_ready = 1'b0;
    set_in(1'b1, 32'h210, 9'h1C3);
    step();
    flush = 1'b1;
    set_in(1'b1, 32'h300, 9'h1FF);
    step();
    flush = 1'b0;
    chk("flush_vld", out_valid, 1'b0);
    chk("flush_ctrl", {WBOut, MEMOut, EXEOut}, 9'h0);
    chk("flush_rdy", in_ready, 1'b1);
    set_in(1'b0, 32'h0, 9'h0);
    out_ready = 1'b1;
    step();
    chk("flush_no300", pcOut, 32'h204);

    // Bubble
    set_in(1'b1, 32'h400, {2'b00, 3'b000, 4'b1010});
    step();
    chk("bub_exe1", EXEOut, 4'b1010);
    set_in(1'b0, 32'h0, 9'h0);
    step();
    chk("bub_exe0", EXEOut, 4'b0000);
    chk("bub_vld", out_valid, 1'b0);
    chk("bub_pc_hold", pcOut, 32'h400);

    // Mixed handshake patterns with a flush in the middle
    for (int i = 0; i < 24; i++) begin
      set_in(pat_v[i], 32'h1000 + 32'(4 * i), 9'(i * 37 + 5));
      out_ready = pat_r[i];
      flush = (i == 13);
      step();
    end
    flush = 1'b0;

    // Reset while both entries are held
    out_ready = 1'b0;
    set_in(1'b1, 32'h500, 9'h0F0);
    step();
    set_in(1'b1, 32'h504, 9'h00F);
    step();
    set_in(1'b1, 32'h508, 9'h1AA);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_in(1'b0, 32'h0, 9'h0);
    chk("rst_skid_vld", out_valid, 1'b0);
    chk("rst_skid_pc", pcOut, 32'h0);
    chk("rst_skid_rdy", in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
